// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
// Optional alarm blinking is enabled with `define SEG_SCHED_BLINK_EN.
package seg_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        ALARM = 2'd2
    } state_e;

    localparam int CNT_W = 24;

    localparam logic [3:0] CODE_OFF         = 4'd0;
    localparam logic [3:0] CODE_OVERCURRENT = 4'd1;
    localparam logic [3:0] CODE_RIGHT       = 4'd2;
    localparam logic [3:0] CODE_CENTER      = 4'd4;
    localparam logic [3:0] CODE_LEFT        = 4'd8;

    localparam int REQ_SRC0  = 0;
    localparam int REQ_SRC1  = 1;
    localparam int REQ_ALARM = 2;

    // Only the five codes the display driver understands pass through.
    function automatic logic [3:0] sanitize_code(input logic [3:0] c);
        logic [3:0] r;
        r = CODE_OFF;
        unique case (c)
            CODE_OVERCURRENT,
            CODE_RIGHT,
            CODE_CENTER,
            CODE_LEFT: r = c;
            default:   r = CODE_OFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Loadable 24-bit down-counter used for dwell and blink timing.
// Holds at zero; expire_o is high whenever the count is zero.
module seg_dwell_timer
    import seg_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/seg_display_scheduler.sv
// Arbitrates two normal sources and an overcurrent alarm onto one display.
// Define SEG_SCHED_BLINK_EN to blink the alarm code while in ALARM.
module seg_display_scheduler
    import seg_sched_pkg::*;
#(
    parameter logic [23:0] DWELL_CYCLES = 24'd12_500_000,
    parameter logic [23:0] BLINK_CYCLES = 24'd6_250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [11:0] code_in,
    output logic [2:0]  gnt,
    output logic [3:0]  number,
    output logic        busy
);

    state_e      state_q;
    state_e      state_d;
    logic [2:0]  gnt_q;
    logic [2:0]  gnt_d;
    logic [3:0]  number_q;
    logic [3:0]  number_d;
    logic        busy_q;
    logic        owner_q;
    logic        owner_d;
    logic        rr_q;
    logic        rr_d;

    logic [1:0]  nreq;
    logic        sel;
    logic        do_grant;
    logic        do_alarm;
    logic        do_idle;
    logic        dwell_load;
    logic        dwell_clr;
    logic        dwell_exp;

    assign nreq = req[REQ_SRC1:REQ_SRC0];

    seg_dwell_timer u_dwell (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (dwell_load),
        .clear_i    (dwell_clr),
        .load_val_i (DWELL_CYCLES - 24'd1),
        .expire_o   (dwell_exp)
    );

`ifdef SEG_SCHED_BLINK_EN
    logic        phase_q;
    logic        phase_d;
    logic [3:0]  alarm_code_q;
    logic [3:0]  alarm_code_d;
    logic        blink_load;
    logic        blink_clr;
    logic        blink_exp;

    seg_dwell_timer u_blink (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (blink_load),
        .clear_i    (blink_clr),
        .load_val_i (BLINK_CYCLES - 24'd1),
        .expire_o   (blink_exp)
    );
`else
    logic unused_blink;
    assign unused_blink = ^BLINK_CYCLES;
`endif

    // Decide what happens this cycle.
    always_comb begin
        do_grant  = 1'b0;
        do_alarm  = 1'b0;
        do_idle   = 1'b0;
        dwell_clr = 1'b0;
        sel       = owner_q;
        unique case (state_q)
            IDLE: begin
                if (req[REQ_ALARM]) begin
                    do_alarm = 1'b1;
                end else if (|nreq) begin
                    do_grant = 1'b1;
                    sel      = (&nreq) ? rr_q : nreq[1];
                end
            end
            DWELL: begin
                if (req[REQ_ALARM]) begin
                    do_alarm  = 1'b1;
                    dwell_clr = 1'b1;
                end else if (dwell_exp) begin
                    if (nreq[~owner_q]) begin
                        do_grant = 1'b1;
                        sel      = ~owner_q;
                    end else if (nreq[owner_q]) begin
                        do_grant = 1'b1;
                        sel      = owner_q;
                    end else begin
                        do_idle = 1'b1;
                    end
                end
            end
            ALARM: begin
                if (!req[REQ_ALARM]) begin
                    do_idle = 1'b1;
                end
            end
            default: begin
                do_idle = 1'b1;
            end
        endcase
    end

    // Apply the decision to the registered outputs.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        number_d   = number_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        dwell_load = 1'b0;
`ifdef SEG_SCHED_BLINK_EN
        phase_d      = phase_q;
        alarm_code_d = alarm_code_q;
        blink_load   = 1'b0;
        blink_clr    = 1'b0;
`endif
        unique case (1'b1)
            do_alarm: begin
                state_d  = ALARM;
                gnt_d    = 3'b100;
                number_d = sanitize_code(code_in[4*REQ_ALARM +: 4]);
`ifdef SEG_SCHED_BLINK_EN
                alarm_code_d = number_d;
                phase_d      = 1'b0;
                blink_load   = 1'b1;
`endif
            end
            do_grant: begin
                state_d    = DWELL;
                gnt_d      = sel ? 3'b010 : 3'b001;
                number_d   = sanitize_code(sel ? code_in[7:4]
                                               : code_in[3:0]);
                owner_d    = sel;
                rr_d       = ~sel;
                dwell_load = 1'b1;
            end
            do_idle: begin
                state_d  = IDLE;
                gnt_d    = 3'b000;
                number_d = CODE_OFF;
`ifdef SEG_SCHED_BLINK_EN
                blink_clr = 1'b1;
`endif
            end
            default: begin
`ifdef SEG_SCHED_BLINK_EN
                if (state_q == ALARM) begin
                    if (blink_exp) begin
                        phase_d    = ~phase_q;
                        blink_load = 1'b1;
                    end
                    number_d = phase_d ? CODE_OFF : alarm_code_q;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 3'b000;
            number_q <= CODE_OFF;
            busy_q   <= 1'b0;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            number_q <= number_d;
            busy_q   <= |gnt_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
        end
    end

`ifdef SEG_SCHED_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= 1'b0;
            alarm_code_q <= CODE_OFF;
        end else begin
            phase_q      <= phase_d;
            alarm_code_q <= alarm_code_d;
        end
    end
`endif

    assign gnt    = gnt_q;
    assign number = number_q;
    assign busy   = busy_q;

endmodule

// File: doc/seg_display_scheduler.md
SEG_DISPLAY_SCHEDULER -- requirements
Module: seg_display_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 24'd12_500_000, minimum cycles a granted code stays displayed (legal 1..2^24-1).
REQ-002 SHALL have parameter BLINK_CYCLES, default 24'd6_250_000, alarm blink half-period (used only with SEG_SCHED_BLINK_EN).
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  3  per-requester display request; [2] = overcurrent alarm, [1:0] = normal sources.
REQ-006 SHALL have port code_in  input  12  requester codes, requester i on [4i+3:4i].
REQ-007 SHALL have port gnt  output  3  one-hot current owner, 0 when idle.
REQ-008 SHALL have port number  output  4  code driven to the seven-segment driver's number input.
REQ-009 SHALL have port busy  output  1  high while state != IDLE.

Function
REQ-010 SHALL implement states IDLE, DWELL, ALARM; all outputs registered.
REQ-011 IDLE: gnt=0, number=0; if req[2] -> ALARM next edge; else if req[1:0]!=0 -> DWELL next edge; grant latency exactly 1 cycle from req sampled.
REQ-012 Normal arbitration SHALL be round-robin: if both req[0] and req[1], grant the one not last served; pointer updates on each normal grant.
REQ-013 On grant, requester's code_in slice SHALL be latched into number in the same edge; later code_in changes ignored until next grant.
REQ-014 Latched code SHALL be one of 0,1,2,4,8; any other value latched as 0.
REQ-015 DWELL SHALL load the dwell counter with DWELL_CYCLES-1 on entry and decrement each cycle; expiry when counter==0 and not reloading.
REQ-016 Dropping req during DWELL SHALL NOT shorten the dwell.
REQ-017 On DWELL expiry: other normal requester asserting -> grant it (new dwell, no IDLE cycle); else owner still requesting -> re-grant owner, relatch code; else -> IDLE.
REQ-018 req[2] high in DWELL SHALL preempt: ALARM next edge, dwell counter cleared, round-robin pointer unchanged.
REQ-019 ALARM: gnt=3'b100, number=latched code_in[11:8] (sanitised per REQ-014); stays while req[2]=1; on req[2]=0 -> IDLE next edge, no minimum dwell.
REQ-020 Simultaneous req[2] and normal requests in IDLE or at dwell expiry SHALL grant req[2].
REQ-021 gnt SHALL always be one-hot or zero; busy SHALL equal |gnt.

Reset
REQ-022 rst_n low SHALL asynchronously force state=IDLE, gnt=0, number=0, busy=0, dwell counter=0, blink counter=0, blink phase=show, round-robin pointer favouring requester 0.
REQ-023 Reset asserted mid-DWELL or mid-ALARM SHALL abandon the grant; first grant after release follows REQ-011.

Configuration
REQ-024 With SEG_SCHED_BLINK_EN defined, ALARM SHALL toggle number between the latched alarm code and 0 every BLINK_CYCLES cycles, starting with the code shown on ALARM entry; blink counter resets on each ALARM entry.
REQ-025 Without SEG_SCHED_BLINK_EN, ALARM SHALL show the latched code steadily and no blink counter SHALL exist.

Structure
REQ-026 Package seg_sched_pkg SHALL hold the state enum, code constants CODE_OFF=0, CODE_OVERCURRENT=1, CODE_RIGHT=2, CODE_CENTER=4, CODE_LEFT=8, and requester index constants REQ_SRC0=0, REQ_SRC1=1, REQ_ALARM=2.
REQ-027 Dwell/blink counting SHALL use one sub-module seg_dwell_timer (24-bit loadable down-counter, load/clear inputs, expire output), instantiated once for dwell and once for blink when enabled.

Verification (DWELL_CYCLES=4, BLINK_CYCLES=2)
REQ-028 Bench: reset release, req=3'b001, code_in[3:0]=8 -> next edge gnt=001, number=8, busy=1; req dropped -> number held 4 cycles then IDLE, number=0.
REQ-029 Bench: req=3'b011, codes 4 and 2 held -> gnt alternates 001/010 every 4 cycles, number 4/2, no IDLE gap.
REQ-030 Bench: req[0] granted, req[2] rises at dwell cycle 2 with code 1 -> next edge gnt=100, number=1; req[2] falls -> IDLE one cycle, then gnt=001 again.
REQ-031 Bench: req=3'b001, code_in[3:0]=4'd5 -> number=0 for the whole dwell, gnt=001.
REQ-032 Bench: rst_n pulsed low mid-ALARM -> gnt, number, busy 0 immediately without a clock edge.
REQ-033 Bench with SEG_SCHED_BLINK_EN: req[2] held, code 1 -> number sequence 1,1,0,0,1,1 from ALARM entry.
